// File: rtl/calc_mac_seq.sv
// calc_mac_seq: sequential multiply-accumulate unit.
// Computes resultado = A*B + C (modo=0) or A*B + C*K (modo=1) using
// shift-add multipliers that retire one multiplier bit per clock. The
// result saturates to all ones on overflow, and overflow is flagged.
module calc_mac_seq #(
    parameter int WIDTH  = 16,
    parameter int KWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [WIDTH-1:0]  C,
    input  logic [KWIDTH-1:0] K,
    input  logic              modo,
    input  logic              inicio,
    output logic              ocupado,
    output logic              pronto,
    output logic [WIDTH-1:0]  resultado,
    output logic              overflow
);

    localparam int MAXW = (WIDTH > KWIDTH) ? WIDTH : KWIDTH;
    localparam int CW   = $clog2(MAXW + 1);
    localparam int P1W  = 2 * WIDTH;
    localparam int P2W  = WIDTH + KWIDTH;
    localparam int SW   = ((P1W > P2W) ? P1W : P2W) + 1;

    localparam logic [CW-1:0] LAST_AB = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_CK = CW'(KWIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        MUL_AB,
        MUL_CK,
        SOMA,
        FIM
    } state_t;

    state_t state;
    state_t state_next;

    logic              modo_r;
    logic [P1W-1:0]    a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  c_r;
    logic [P2W-1:0]    c_sh;
    logic [KWIDTH-1:0] k_sh;
    logic [P1W-1:0]    acc1;
    logic [P2W-1:0]    acc2;
    logic [CW-1:0]     cnt;
    logic [SW-1:0]     sum;
    logic              sat;

    // Full-width final sum; any bit above WIDTH means the result must saturate
    always_comb begin
        sum = SW'(acc1) + (modo_r ? SW'(acc2) : SW'(c_r));
        sat = |sum[SW-1:WIDTH];
    end

    // State register; reset aborts whatever operation is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state selection: each multiply phase ends after its last multiplier bit
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (inicio) state_next = MUL_AB;
            MUL_AB:  if (cnt == LAST_AB) state_next = modo_r ? MUL_CK : SOMA;
            MUL_CK:  if (cnt == LAST_CK) state_next = SOMA;
            SOMA:    state_next = FIM;
            FIM:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, shift-add iterations, saturation and handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            modo_r    <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            c_r       <= '0;
            c_sh      <= '0;
            k_sh      <= '0;
            acc1      <= '0;
            acc2      <= '0;
            cnt       <= '0;
            ocupado   <= 1'b0;
            pronto    <= 1'b0;
            resultado <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (inicio) begin
                        a_sh    <= P1W'(A);
                        b_sh    <= B;
                        c_r     <= C;
                        c_sh    <= P2W'(C);
                        k_sh    <= K;
                        modo_r  <= modo;
                        acc1    <= '0;
                        acc2    <= '0;
                        cnt     <= '0;
                        ocupado <= 1'b1;
                    end
                end
                MUL_AB: begin
                    if (b_sh[0]) acc1 <= acc1 + a_sh;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= (cnt == LAST_AB) ? '0 : cnt + CW'(1);
                end
                MUL_CK: begin
                    if (k_sh[0]) acc2 <= acc2 + c_sh;
                    c_sh <= c_sh << 1;
                    k_sh <= k_sh >> 1;
                    cnt  <= (cnt == LAST_CK) ? '0 : cnt + CW'(1);
                end
                SOMA: begin
                    resultado <= sat ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
                    overflow  <= sat;
                    pronto    <= 1'b1;
                end
                FIM: begin
                    pronto  <= 1'b0;
                    ocupado <= 1'b0;
                end
                default: begin
                    pronto  <= 1'b0;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule
